// File: rtl/dk_sound_mixer_if.sv
// Sample bus between the sound generators / audio output path and the mixer.
// Carries the per-sample strobe, packed channel samples and gains, and the mixed result.
interface dk_sound_mixer_if #(
  parameter int NUM_CH = 4
);
  logic                   audio_clk_en;
  logic [NUM_CH*16-1:0]   ch_in;
  logic [NUM_CH*8-1:0]    gains;
  logic [15:0]            out;
  logic                   out_valid;
  logic                   busy;
  logic                   overrun;

  modport master (
    output audio_clk_en, ch_in, gains,
    input  out, out_valid, busy, overrun
  );

  modport slave (
    input  audio_clk_en, ch_in, gains,
    output out, out_valid, busy, overrun
  );
endinterface

// File: rtl/dk_sound_mixer.sv
// Gain-scaled channel mixer: one shared MAC step per channel, saturation to 16 bits,
// and an optional first-order DC blocker ahead of the output register.
module dk_sound_mixer #(
  parameter int NUM_CH    = 4,
  parameter int DCB_EN    = 1,
  parameter int DCB_SHIFT = 8
) (
  input  logic             clk,
  input  logic             reset,
  dk_sound_mixer_if.slave  bus
);

  localparam int IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = 16 + 9 + $clog2(NUM_CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] DCB  = 2'd2;

  logic [1:0]              state;
  logic [IW-1:0]           idx;
  logic signed [15:0]      snap_ch   [NUM_CH];
  logic [7:0]              snap_gain [NUM_CH];
  logic signed [ACC_W-1:0] acc;
  logic signed [15:0]      x_prev;
  logic signed [15:0]      y_prev;
  logic signed [15:0]      out_r;
  logic                    out_valid_r;
  logic                    overrun_r;

  logic signed [24:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] mix_wide;
  logic signed [15:0]      mix_sat;
  logic signed [18:0]      y_full;
  logic signed [15:0]      y_sat;
  logic signed [15:0]      y_out;

  always_comb begin
    prod     = 25'(snap_ch[idx]) * 25'($signed({1'b0, snap_gain[idx]}));
    prod_ext = ACC_W'(prod);

    // Gains are Q1.7, so the sum carries 7 fractional bits; >>> floors toward -inf.
    mix_wide = acc >>> 7;
    if (mix_wide[ACC_W-1:15] == '0 || mix_wide[ACC_W-1:15] == '1)
      mix_sat = mix_wide[15:0];
    else
      mix_sat = mix_wide[ACC_W-1] ? 16'sh8000 : 16'sh7fff;

    y_full = 19'(mix_sat) - 19'(x_prev) + 19'(y_prev) - 19'(y_prev >>> DCB_SHIFT);
    if (y_full[18:15] == '0 || y_full[18:15] == '1)
      y_sat = y_full[15:0];
    else
      y_sat = y_full[18] ? 16'sh8000 : 16'sh7fff;

    y_out = (DCB_EN != 0) ? y_sat : mix_sat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      acc         <= '0;
      x_prev      <= '0;
      y_prev      <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        snap_ch[i]   <= '0;
        snap_gain[i] <= '0;
      end
    end else begin
      out_valid_r <= 1'b0;
      if (bus.audio_clk_en && state != IDLE)
        overrun_r <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.audio_clk_en) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              snap_ch[i]   <= bus.ch_in[16*i +: 16];
              snap_gain[i] <= bus.gains[8*i +: 8];
            end
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (idx == LAST_IDX)
            state <= DCB;
          else
            idx <= idx + IW'(1);
        end
        DCB: begin
          out_r       <= y_out;
          out_valid_r <= 1'b1;
          if (DCB_EN != 0) begin
            x_prev <= mix_sat;
            y_prev <= y_sat;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = (state != IDLE);
  assign bus.overrun   = overrun_r;

endmodule

// File: doc/dk_sound_mixer.md
Name: dk_sound_mixer

Overview:
- Downstream consumer of the per-effect discrete sound generators (walk, jump, stomp, etc.), each producing a signed 16-bit sample per audio_clk_en.
- Once per sample it captures all channel samples and gain-scales them with one time-multiplexed multiplier.
- It then sums the channels, saturates the sum, optionally removes DC with a first-order blocker, and presents one signed 16-bit sample with a valid pulse to the audio output path.

Parameters:
- NUM_CH, 4, number of input channels (1..8).
- DCB_EN, 1, 1 enables the DC-blocking high-pass; 0 bypasses it.
- DCB_SHIFT, 8, leak shift k of the DC blocker; pole = 1 - 2^-k (range 1..15).

Ports:
- clk  input  1  system clock, same clock as the sound generators.
- reset  input  1  asynchronous, active-high reset.
- audio_clk_en  input  1  one-cycle sample strobe, shared with the generators.
- ch_in  input  NUM_CH*16  packed signed samples; channel i in bits [16i+15:16i].
- gains  input  NUM_CH*8  packed unsigned gains, Q1.7 (128 = unity); channel i in bits [8i+7:8i].
- out  output  16  signed mixed sample, registered.
- out_valid  output  1  one-cycle pulse when out updates.
- busy  output  1  high while a sample is being processed (state != IDLE).
- overrun  output  1  sticky; set when a strobe arrives while busy.

Behaviour:
- Reset (asynchronous):
  - out = 0, out_valid = 0, busy = 0, overrun = 0.
  - Accumulator, snapshot registers and DC-blocker history (x_prev, y_prev) are cleared to 0.
  - State goes to IDLE and the channel index to 0.
  - Reset asserted mid-operation aborts the sample in progress; no out_valid is produced for it.
- State IDLE:
  - On a clk edge with audio_clk_en = 1, capture all of ch_in and gains into snapshot registers.
  - Clear the accumulator, set idx = 0, go to MAC.
  - Later changes on ch_in and gains do not affect the captured sample.
- State MAC:
  - One channel per edge: acc += snap_ch[idx] * $signed({1'b0, snap_gain[idx]}).
  - idx increments; after idx = NUM_CH-1 go to DCB.
  - Takes exactly NUM_CH edges.
- Accumulator width:
  - 16 + 9 + clog2(NUM_CH) bits, signed.
  - No intermediate overflow is possible.
- State DCB (single edge):
  - mix = acc >>> 7 (arithmetic shift, floor), saturated to [-32768, 32767].
  - If DCB_EN = 1: y = mix - x_prev + y_prev - (y_prev >>> DCB_SHIFT).
    - Compute y at full width, then saturate to 16 bits.
    - Update x_prev = mix and y_prev = saturated y.
  - If DCB_EN = 0: y = mix; the history registers are unused.
  - out <= y, out_valid <= 1 for exactly one cycle, go to IDLE.
- Latency: out_valid is high in the cycle following edge NUM_CH+1 after the capture edge (5 clocks for NUM_CH = 4).
- Overrun:
  - audio_clk_en = 1 in any state other than IDLE (including DCB) is ignored for capture.
  - It sets overrun = 1, which holds until reset.
  - The processing in progress completes unaffected.
- Clock budget: CLOCK_RATE / SAMPLE_RATE must be ≥ NUM_CH + 2 for overrun-free operation; this is the integrator's responsibility.
- busy is high from the edge after capture until the edge that sets out_valid, inclusive of the DCB state.
- out holds its value between updates.

Test Plan:
- DCB_EN = 0, NUM_CH = 4, ch0 = 1000 at gain 128, other channels 0 at gain 0, one strobe -> out_valid pulses exactly 5 clocks after the strobe edge, out = 1000, busy high for 5 cycles.
- DCB_EN = 0:
  - All channels 30000 at gain 255 -> out = 32767.
  - All channels -32768 at gain 255 -> out = -32768.
  - ch0 = -3 at gain 64 -> out = -2 (floor of -1.5).
- DCB_EN = 1, DCB_SHIFT = 4, ch0 constant 1000 at gain 128, three successive strobes -> out = 1000, then 938, then 880.
- Second strobe 2 cycles after the first -> overrun = 1 and stays set, only one out_valid pulse, out equals the first sample's result.
- Reset pulse during MAC (idx = 2) -> out = 0, busy = 0, overrun = 0, no out_valid; the next strobe processes normally.
- ch_in changed 1 cycle after the capture strobe -> out reflects the captured values, not the new ones.
